// File: rtl/int_res_arbiter.sv
// Round-robin, burst-locked arbiter sharing int_res_mem's single read/write port pair; grant lands one IDLE cycle after a request.
// A transfer is combinational with the owner's valid; non-owners see req_ready low; read data returns READ_LATENCY cycles later, routed by tag.
module int_res_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ-1:0]        req_width,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_chip_en,
  output logic                      mem_read_en,
  output logic [ADDR_W-1:0]         mem_read_addr,
  output logic                      mem_read_width,
  input  logic [DATA_W-1:0]         mem_read_data,
  output logic                      mem_write_en,
  output logic [ADDR_W-1:0]         mem_write_addr,
  output logic                      mem_write_width,
  output logic [DATA_W-1:0]         mem_write_data
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] IDX_LAST = OW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic          vld;
    logic [OW-1:0] tag;
  } rd_tag_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [OW-1:0]     cand;
  logic [OW-1:0]     pick_idx;
  logic              pick_vld;
  logic [OW-1:0]     owner_inc;
  rd_tag_t           tag_pipe_q [READ_LATENCY];
  rd_tag_t           tag_tail;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic              own_vld;
  logic              own_write;
  logic              own_last;
  logic              own_width;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              xfer;
  logic              rel_burst;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Walk offsets from the far end so the candidate closest to rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = OW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign own_vld   = req_valid[owner_q];
  assign own_write = req_write[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_width = req_width[owner_q];
  assign own_addr  = addr_arr[owner_q];
  assign own_data  = data_arr[owner_q];

  assign owner_inc = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
  assign xfer      = (state_q == LOCKED) & own_vld;
  assign rel_burst = xfer & (own_last | (burst_cnt_q == CNT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // An idle owner keeps the lock; only a completed transfer can release it.
        if (rel_burst) begin
          state_d     = IDLE;
          rr_ptr_d    = owner_inc;
          burst_cnt_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = '0;
    mem_read_en     = 1'b0;
    mem_read_addr   = '0;
    mem_read_width  = 1'b0;
    mem_write_en    = 1'b0;
    mem_write_addr  = '0;
    mem_write_width = 1'b0;
    mem_write_data  = '0;
    mem_chip_en     = (state_q == LOCKED) | (|req_valid);
    if (state_q == LOCKED) begin
      req_ready[owner_q] = 1'b1;
      if (own_vld) begin
        if (own_write) begin
          mem_write_en    = 1'b1;
          mem_write_addr  = own_addr;
          mem_write_width = own_width;
          mem_write_data  = own_data;
        end else begin
          mem_read_en    = 1'b1;
          mem_read_addr  = own_addr;
          mem_read_width = own_width;
        end
      end
    end
  end

  // Tags ride alongside the memory's read latency so responses survive a handover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_pipe_q[i] <= '0;
      end
    end else begin
      tag_pipe_q[0] <= '{vld: mem_read_en, tag: owner_q};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign tag_tail = tag_pipe_q[READ_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_tail.vld) begin
      rsp_valid[tag_tail.tag] = 1'b1;
      rsp_data                = mem_read_data;
    end
  end

endmodule

// File: tb/tb_int_res_arbiter.sv
// Directed and random checks of int_res_arbiter against a transaction-level reference model.
module tb_int_res_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_write = '0, req_last = '0, req_width = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data, mem_read_data, mem_write_data;
  logic            mem_chip_en, mem_read_en, mem_read_width, mem_write_en, mem_write_width;
  logic [AW-1:0]   mem_read_addr, mem_write_addr;

  always #5 clk = ~clk;

  int_res_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_last(req_last),
    .req_width(req_width), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_chip_en(mem_chip_en),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_width(mem_read_width),
    .mem_read_data(mem_read_data), .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_width(mem_write_width), .mem_write_data(mem_write_data));

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hA500_0000 + 32'(a) * 32'h0001_0001;
  endfunction

  // Memory environment: fixed read latency, writes land at the clock edge.
  logic [DW-1:0] tbmem [256];
  bit            wv    [256];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (mem_read_en)
      rd_pipe[0] <= wv[mem_read_addr[7:0]] ? tbmem[mem_read_addr[7:0]] : init_word(int'(mem_read_addr[7:0]));
    else
      rd_pipe[0] <= DW'($urandom);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_write_en) begin
      tbmem[mem_write_addr[7:0]] <= mem_write_data;
      wv[mem_write_addr[7:0]]    <= 1'b1;
    end
  end
  assign mem_read_data = rd_pipe[RL-1];

  typedef struct packed {
    logic          wr;
    logic          last;
    logic          wid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    gap;
  } xfer_t;
  typedef struct { int due; int tag; logic [DW-1:0] data; } pend_t;
  typedef struct { int cyc; int who; bit wr; logic [AW-1:0] addr; logic [N-1:0] rsp; logic [DW-1:0] rdat; } obs_t;
  typedef struct { int cyc; logic [N-1:0] rsp; logic [DW-1:0] rdat; } rsp_t;

  xfer_t         sq [N][256];
  int            hd [N];
  int            tl [N];
  bit            m_locked;
  int            m_owner, m_ptr, m_cnt, cyc;
  logic [DW-1:0] ref_mem [256];
  pend_t         pend [$];
  obs_t          obs [$];
  rsp_t          rlog [$];
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : 99;
    return r;
  endfunction

  task automatic push(input int r, input bit wr, input bit last, input bit wid,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data, input int gap);
    xfer_t x;
    x.wr = wr; x.last = last; x.wid = wid; x.addr = addr; x.data = data; x.gap = 8'(gap);
    sq[r][tl[r]] = x;
    tl[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!rst && hd[i] != tl[i] && sq[i][hd[i]].gap == 8'd0) begin
        req_valid[i] = 1'b1;
        req_write[i] = sq[i][hd[i]].wr;
        req_last[i]  = sq[i][hd[i]].last;
        req_width[i] = sq[i][hd[i]].wid;
        req_addr[i*AW +: AW] = sq[i][hd[i]].addr;
        req_data[i*DW +: DW] = sq[i][hd[i]].data;
      end else begin
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_last[i]  = 1'($urandom);
        req_width[i] = 1'($urandom);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic check();
    logic [N-1:0]  e_ready, e_rsp;
    logic [DW-1:0] e_rdat;
    bit            e_rd, e_wr, e_chip;
    xfer_t         x;
    obs_t          o;
    rsp_t          rr;
    e_ready = '0; e_rsp = '0; e_rdat = '0; e_rd = 0; e_wr = 0; e_chip = 0; x = '0;
    if (!rst) begin
      e_chip = m_locked || (req_valid != '0);
      if (m_locked) begin
        e_ready[m_owner] = 1'b1;
        if (req_valid[m_owner]) begin
          x    = sq[m_owner][hd[m_owner]];
          e_rd = !x.wr;
          e_wr = x.wr;
        end
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_rsp[pend[0].tag] = 1'b1;
        e_rdat = pend[0].data;
      end
    end
    chk($sformatf("req_ready@%0d", cyc), 64'(req_ready), 64'(e_ready));
    chk($sformatf("mem_read_en@%0d", cyc), 64'(mem_read_en), 64'(e_rd));
    chk($sformatf("mem_write_en@%0d", cyc), 64'(mem_write_en), 64'(e_wr));
    chk($sformatf("mem_chip_en@%0d", cyc), 64'(mem_chip_en), 64'(e_chip));
    chk($sformatf("rsp_valid@%0d", cyc), 64'(rsp_valid), 64'(e_rsp));
    chk($sformatf("rsp_data@%0d", cyc), 64'(rsp_data), 64'(e_rdat));
    if (e_rd) begin
      chk($sformatf("rd_addr@%0d", cyc), 64'(mem_read_addr), 64'(x.addr));
      chk($sformatf("rd_width@%0d", cyc), 64'(mem_read_width), 64'(x.wid));
    end
    if (e_wr) begin
      chk($sformatf("wr_addr@%0d", cyc), 64'(mem_write_addr), 64'(x.addr));
      chk($sformatf("wr_data@%0d", cyc), 64'(mem_write_data), 64'(x.data));
      chk($sformatf("wr_width@%0d", cyc), 64'(mem_write_width), 64'(x.wid));
    end
    if (mem_read_en || mem_write_en) begin
      o.cyc = cyc; o.who = onehot_idx(req_ready); o.wr = mem_write_en;
      o.addr = mem_write_en ? mem_write_addr : mem_read_addr;
      o.rsp = rsp_valid; o.rdat = rsp_data;
      obs.push_back(o);
    end
    if (rsp_valid != '0) begin
      rr.cyc = cyc; rr.rsp = rsp_valid; rr.rdat = rsp_data;
      rlog.push_back(rr);
    end
  endtask

  // Reference model: one owner at a time, rotating start point, bounded bursts.
  task automatic update();
    xfer_t x;
    pend_t p;
    bit    found;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      pend.delete();
      for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
      for (int i = 0; i < N; i++)
        if (hd[i] != tl[i] && sq[i][hd[i]].gap != 8'd0) sq[i][hd[i]].gap = sq[i][hd[i]].gap - 8'd1;
      if (m_locked) begin
        if (req_valid[m_owner]) begin
          x = sq[m_owner][hd[m_owner]];
          hd[m_owner]++;
          if (x.wr) ref_mem[x.addr[7:0]] = x.data;
          else begin
            p.due = cyc + RL; p.tag = m_owner; p.data = ref_mem[x.addr[7:0]];
            pend.push_back(p);
          end
          if (x.last || m_cnt == MB - 1) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
          end else m_cnt++;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1; m_owner = (m_ptr + k) % N; m_locked = 1;
          end
      end
      for (int i = 0; i < N; i++) if (hd[i] == tl[i]) begin hd[i] = 0; tl[i] = 0; end
    end
    cyc++;
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            o0, r0, s, len, gap;
    bit            lastflag;
    logic [DW-1:0] newd;
    int            exp_who, exp_diff;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; cyc = 0;

    do_reset();
    chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, mem_read_en, mem_write_en, mem_chip_en}), 64'd0);

    // 1: requester 2 alone, three reads
    do_reset();
    o0 = obs.size(); r0 = rlog.size(); s = cyc;
    for (int k = 0; k < 3; k++) push(2, 0, k == 2, k[0], AW'(16'h10 + k), '0, 0);
    idle(10);
    chk("t1_nreads", 64'(obs.size() - o0), 64'd3);
    for (int k = 0; k < 3; k++) if (o0 + k < obs.size()) begin
      chk($sformatf("t1_who%0d", k), 64'(obs[o0+k].who), 64'd2);
      chk($sformatf("t1_addr%0d", k), 64'(obs[o0+k].addr), 64'(16'h10 + k));
      chk($sformatf("t1_cyc%0d", k), 64'(obs[o0+k].cyc), 64'(s + 1 + k));
    end
    chk("t1_nrsp", 64'(rlog.size() - r0), 64'd3);
    for (int k = 0; k < 3; k++) if (r0 + k < rlog.size()) begin
      chk($sformatf("t1_rsp%0d", k), 64'(rlog[r0+k].rsp), 64'(4'b0100));
      chk($sformatf("t1_rcyc%0d", k), 64'(rlog[r0+k].cyc), 64'(s + 3 + k));
      chk($sformatf("t1_rdat%0d", k), 64'(rlog[r0+k].rdat), 64'(init_word(16'h10 + k)));
    end

    // 2: all four contend with single-write bursts
    do_reset();
    o0 = obs.size();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < N; r++) push(r, 1, 1, r[0], AW'(16'h40 + 4*rep + r), DW'($urandom), 0);
    idle(20);
    chk("t2_nwrites", 64'(obs.size() - o0), 64'd8);
    for (int k = 0; k < 5; k++) if (o0 + k < obs.size()) begin
      chk($sformatf("t2_owner%0d", k), 64'(obs[o0+k].who), 64'(k % N));
      if (k > 0) chk($sformatf("t2_gap%0d", k), 64'(obs[o0+k].cyc - obs[o0+k-1].cyc), 64'd2);
    end

    // 3: forced release after MAX_BURST transfers
    do_reset();
    o0 = obs.size();
    for (int k = 0; k < 20; k++) push(1, 1, k == 19, 0, AW'(16'h80 + k), DW'($urandom), 0);
    push(3, 1, 1, 1, 16'hC0, DW'($urandom), 0);
    idle(40);
    chk("t3_nwrites", 64'(obs.size() - o0), 64'd21);
    for (int k = 0; k < 21; k++) if (o0 + k < obs.size()) begin
      exp_who = (k == 16) ? 3 : 1;
      chk($sformatf("t3_owner%0d", k), 64'(obs[o0+k].who), 64'(exp_who));
      if (k == 16 || k == 17)
        chk($sformatf("t3_handover%0d", k), 64'(obs[o0+k].cyc - obs[o0+k-1].cyc), 64'd2);
    end

    // 4: read then immediate write to the same address by the next owner
    do_reset();
    o0 = obs.size();
    newd = 32'h1234_5678;
    push(0, 0, 1, 0, 16'h20, '0, 0);
    push(1, 1, 1, 1, 16'h20, newd, 0);
    push(2, 0, 1, 0, 16'h20, '0, 0);
    idle(12);
    chk("t4_nxfer", 64'(obs.size() - o0), 64'd3);
    if (o0 + 2 < obs.size()) begin
      chk("t4_rd_owner", 64'(obs[o0].who), 64'd0);
      chk("t4_wr_owner", 64'(obs[o0+1].who), 64'd1);
      chk("t4_wr_is_write", 64'(obs[o0+1].wr), 64'd1);
      chk("t4_rsp_with_wr", 64'(obs[o0+1].rsp), 64'(4'b0001));
      chk("t4_old_data", 64'(obs[o0+1].rdat), 64'(init_word(16'h20)));
      chk("t4_wr_cycle", 64'(obs[o0+1].cyc - obs[o0].cyc), 64'd2);
    end
    if (rlog.size() > 0) begin
      chk("t4_readback_tag", 64'(rlog[rlog.size()-1].rsp), 64'(4'b0100));
      chk("t4_readback_data", 64'(rlog[rlog.size()-1].rdat), 64'(newd));
    end

    // 5: owner idles mid-burst; grant and count survive the gap
    do_reset();
    o0 = obs.size();
    for (int k = 0; k < 17; k++) push(0, 1, k == 16, 0, AW'(16'h90 + k), DW'($urandom), (k == 8) ? 5 : 0);
    idle(45);
    chk("t5_nwrites", 64'(obs.size() - o0), 64'd17);
    for (int k = 1; k < 17; k++) if (o0 + k < obs.size()) begin
      exp_diff = (k == 8) ? 6 : (k == 16) ? 2 : 1;
      chk($sformatf("t5_owner%0d", k), 64'(obs[o0+k].who), 64'd0);
      chk($sformatf("t5_spacing%0d", k), 64'(obs[o0+k].cyc - obs[o0+k-1].cyc), 64'(exp_diff));
    end

    // 6: reset one cycle after a read drops the response
    do_reset();
    o0 = obs.size(); r0 = rlog.size();
    push(2, 0, 1, 0, 16'h30, '0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(8);
    chk("t6_nreads", 64'(obs.size() - o0), 64'd1);
    chk("t6_no_rsp", 64'(rlog.size() - r0), 64'd0);
    chk("t6_outputs", 64'({req_ready, rsp_valid, mem_read_en, mem_write_en, mem_chip_en}), 64'd0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++) begin
        if (hd[r] == tl[r] && $urandom_range(0, 3) == 0) begin
          len = int'($urandom_range(1, 20));
          lastflag = ($urandom_range(0, 3) != 0);
          for (int k = 0; k < len; k++) begin
            gap = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            push(r, 1'($urandom), lastflag && (k == len - 1), 1'($urandom),
                 AW'($urandom_range(0, 255)), DW'($urandom), gap);
          end
        end
      end
      tick();
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
